// File: rtl/fixed_mac_accum_if.sv
// fixed_mac_accum_if: product input stream and summed-sample output stream of the MAC accumulator
interface fixed_mac_accum_if #(
  parameter int SIZE = 32,
  parameter int CW   = 2
);
  logic [SIZE-1:0] in_product;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] out_sum;
  logic            out_sat;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   tap_count;
  modport master (
    output in_product, in_valid, out_ready,
    input  in_ready, out_sum, out_sat, out_valid, tap_count
  );
  modport slave (
    input  in_product, in_valid, out_ready,
    output in_ready, out_sum, out_sat, out_valid, tap_count
  );
endinterface

// File: rtl/fixed_mac_accum.sv
// fixed_mac_accum: sums TAPS signed Q16.16 products in a guard-bit accumulator, saturates to SIZE bits
module fixed_mac_accum #(
  parameter int SIZE  = 32,
  parameter int TAPS  = 4,
  parameter int GUARD = 8
) (
  input logic            clk,
  input logic            resetn,
  fixed_mac_accum_if.slave bus
);
  localparam int CW = TAPS > 1 ? $clog2(TAPS) : 1;
  localparam int AW = SIZE + GUARD;
  localparam logic [SIZE-1:0] SMAX = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0] SMIN = {1'b1, {(SIZE-1){1'b0}}};
  logic [AW-1:0]   acc;
  logic [AW-1:0]   prod_x;
  logic [AW-1:0]   total;
  logic [GUARD:0]  top;
  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] sum_q;
  logic            sat_q;
  logic            valid_q;
  logic            accept;
  logic            last;
  logic            ovf;
  assign prod_x = {{GUARD{bus.in_product[SIZE-1]}}, bus.in_product};
  // first tap of a group starts fresh, so a stale accumulator never leaks in
  assign total  = cnt == '0 ? prod_x : acc + prod_x;
  assign top    = total[AW-1:SIZE-1];
  assign ovf    = !(&top || ~|top);
  assign last   = cnt == CW'(TAPS - 1);
  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_sum   = sum_q;
  assign bus.out_sat   = sat_q;
  assign bus.out_valid = valid_q;
  assign bus.tap_count = cnt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      cnt     <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (bus.out_ready) valid_q <= 1'b0;
      if (accept && last) begin
        sum_q   <= ovf ? (total[AW-1] ? SMIN : SMAX) : total[SIZE-1:0];
        sat_q   <= ovf;
        valid_q <= 1'b1;
        cnt     <= '0;
      end else if (accept) begin
        acc <= total;
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fixed_mac_accum.sv
// tb_fixed_mac_accum: directed and randomized checks of fixed_mac_accum against a group-sum model
module tb_fixed_mac_accum;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  fixed_mac_accum_if #(.SIZE(32), .CW(2)) b0 ();
  fixed_mac_accum_if #(.SIZE(32), .CW(1)) b1 ();

  fixed_mac_accum #(.SIZE(32), .TAPS(4), .GUARD(8)) dut  (.clk(clk), .resetn(resetn), .bus(b0));
  fixed_mac_accum #(.SIZE(32), .TAPS(1), .GUARD(8)) dut1 (.clk(clk), .resetn(resetn), .bus(b1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] satf(input longint s);
    if (s > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, s[31:0]};
  endfunction

  logic [32:0] expq[$];
  logic [32:0] r;
  longint msum = 0;
  int mcnt = 0;
  int nres = 0;
  logic hold = 1'b0;
  logic [31:0] hsum;
  logic hsat;
  logic [31:0] last_sum = '0;
  logic last_sat = 1'b0;
  bit rnd = 0;

  // reference: a result is the saturated plain sum of every 4 accepted products
  always @(negedge clk) begin
    if (!resetn) begin
      expq.delete();
      msum = 0;
      mcnt = 0;
      hold = 1'b0;
    end else begin
      chk("in_ready", b0.in_ready, (b0.out_valid && !b0.out_ready) ? 1'b0 : 1'b1);
      chk("tap_count", b0.tap_count, mcnt);
      chk("out_valid", b0.out_valid, expq.size() > 0);
      if (hold) begin
        chk("hold_sum", b0.out_sum, hsum);
        chk("hold_sat", b0.out_sat, hsat);
      end
      hold = b0.out_valid && !b0.out_ready;
      hsum = b0.out_sum;
      hsat = b0.out_sat;
      if (b0.out_valid && b0.out_ready && expq.size() > 0) begin
        r = expq.pop_front();
        chk("out_sum", b0.out_sum, r[31:0]);
        chk("out_sat", b0.out_sat, r[32]);
        last_sum = b0.out_sum;
        last_sat = b0.out_sat;
        nres++;
      end
      if (b0.in_valid && b0.in_ready) begin
        msum += longint'($signed(b0.in_product));
        mcnt++;
        if (mcnt == 4) begin
          expq.push_back(satf(msum));
          msum = 0;
          mcnt = 0;
        end
      end
    end
  end

  logic pend1 = 1'b0;
  logic [31:0] pv1;
  always @(negedge clk) begin
    if (!resetn) pend1 = 1'b0;
    else begin
      chk("t1_valid", b1.out_valid, pend1);
      chk("t1_ready", b1.in_ready, 1'b1);
      if (pend1) chk("t1_sum", b1.out_sum, pv1);
      pend1 = b1.in_valid && b1.in_ready;
      pv1 = b1.in_product;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd) b0.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [31:0] p, input int gap);
    int k;
    repeat (gap) begin @(posedge clk); #1; end
    b0.in_valid = 1'b1;
    b0.in_product = p;
    k = 0;
    @(negedge clk);
    while (!b0.in_ready && k < 200) begin k++; @(negedge clk); end
    if (k == 200) chk("accept_timeout", k, 0);
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
  endtask

  task automatic group(input logic [31:0] p0, p1, p2, p3, input logic [31:0] es, input logic esat, input string tag);
    send(p0, 0); send(p1, 0); send(p2, 0); send(p3, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk({tag, "_sum"}, last_sum, es);
    chk({tag, "_sat"}, last_sat, esat);
  endtask

  initial begin
    logic [31:0] p;
    int base;
    b0.in_valid = 1'b0; b0.in_product = '0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_product = '0; b1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sum", b0.out_sum, 0);
    chk("rst_valid", b0.out_valid, 0);
    chk("rst_tap", b0.tap_count, 0);
    resetn = 1'b1;
    group(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0004_0000, 1'b0, "basic");
    group(32'h0001_8000, 32'hFFFF_0000, 32'h0000_4000, 32'hFFFF_C000, 32'h0000_8000, 1'b0, "mix");
    group(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 1'b1, "sat_hi");
    group(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, "sat_lo");
    group(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, "zero");
    b0.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h0001_0000, 0);
    b0.in_valid = 1'b1;
    b0.in_product = 32'h0001_0000;
    repeat (5) begin @(negedge clk); chk("hold_in_ready", b0.in_ready, 0); end
    @(posedge clk); #1;
    b0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h0001_0000, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("stream_sum", last_sum, 32'h0004_0000);
    base = nres;
    for (int i = 0; i < 12; i++) send(32'h0001_0000, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("b2b_count", nres - base, 3);
    for (int i = 0; i < 4; i++) send(32'h0001_0000, $urandom_range(0, 3));
    repeat (2) begin @(posedge clk); #1; end
    chk("bubble_sum", last_sum, 32'h0004_0000);
    send(32'h0001_0000, 0); send(32'h0001_0000, 0);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", b0.out_valid, 0);
    chk("mid_rst_tap", b0.tap_count, 0);
    chk("mid_rst_sum", b0.out_sum, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    group(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0004_0000, 1'b0, "post_rst");
    rnd = 1;
    for (int i = 0; i < 160; i++) begin
      p = $urandom;
      if ($urandom_range(0, 3) != 0) p = {{14{p[17]}}, p[17:0]};
      send(p, $urandom_range(0, 2));
    end
    rnd = 0;
    @(posedge clk); #2;
    b0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("drain", expq.size(), 0);
    b1.in_valid = 1'b1;
    b1.in_product = 32'h0002_0000;
    repeat (6) begin @(posedge clk); #1; end
    chk("t1_const", b1.out_sum, 32'h0002_0000);
    for (int i = 0; i < 20; i++) begin
      b1.in_valid = 1'($urandom_range(0, 1));
      b1.in_product = $urandom;
      @(posedge clk); #1;
    end
    b1.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
